fb_scanout: RTL and testbench
=============================

# fb_scanout

Display scan-out engine that sits directly downstream of `frame_buffer`. It generates raster timing, meaning hsync, vsync and data-enable, for a fixed active window. It also drives the frame buffer's read port (`addr_rd0` / `Data_out0`) in linear raster order and realigns the returned 16-bit pixels with the timing signals. Pixels are produced at one per clock, and the whole block runs in the frame-buffer clock domain.

## Interface

Parameters:
- `ADDR_WIDTH`, 32: width of the read address; matches `frame_buffer`.
- `DATA_WIDTH`, 16: pixel width; matches `frame_buffer`.
- `H_ACTIVE`, 128: active pixels per line.
- `H_FP`, 8: horizontal front porch (cycles).
- `H_SYNC`, 16: hsync pulse width (cycles).
- `H_BP`, 8: horizontal back porch (cycles). With defaults, H_TOTAL is 160.
- `V_ACTIVE`, 80: active lines. With defaults, H_ACTIVE × V_ACTIVE = 10240, which fills all ten 1024-deep BRAMs.
- `V_FP`, 2: vertical front porch (lines).
- `V_SYNC`, 2: vsync width (lines).
- `V_BP`, 4: vertical back porch (lines). With defaults, V_TOTAL is 88.
- `SYNC_ACTIVE`, 0: asserted level of hsync_o/vsync_o.

Ports:
- `clk_i`, in, 1: clock. Same clock as `frame_buffer`.
- `resetn_i`, in, 1: reset. Asynchronous, active-low.
- `en_i`, in, 1: scan enable.
- `addr_rd_o`, out, ADDR_WIDTH: connects to `addr_rd0`.
- `data_i`, in, DATA_WIDTH: connects to `Data_out0`. Valid one cycle after the address is presented.
- `pixel_o`, out, DATA_WIDTH: output pixel.
- `de_o`, out, 1: active-video enable.
- `hsync_o`, out, 1: horizontal sync.
- `vsync_o`, out, 1: vertical sync.
- `frame_start_o`, out, 1: one-cycle pulse, coincident with the first active pixel of each frame.
- `busy_o`, out, 1: high while a frame is being scanned.

## Operation

- **Counters.**
  - `h_cnt` runs 0..H_TOTAL-1.
  - `v_cnt` runs 0..V_TOTAL-1 and increments when `h_cnt` wraps.
  - A frame ends when both counters are at their maximum.
- **Active region.** `h_cnt < H_ACTIVE` and `v_cnt < V_ACTIVE`.
- **hsync window.** Asserted for H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC.
- **vsync window.** Asserted for whole lines, V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC.
- **Read address.**
  - Generated by an incrementer; no multiplier is used.
  - Set to 0 at frame start.
  - Increments by 1 after each active pixel.
  - Holds its value during blanking.
  - Never exceeds H_ACTIVE×V_ACTIVE−1.
- **State machine: IDLE → RUN → STOP → IDLE.**
  - IDLE: counters are held at (0,0), all outputs are at reset values, and `busy_o` = 0. Moves to RUN when `en_i` = 1.
  - RUN: scans frames continuously and `busy_o` = 1. If `en_i` = 0 when the last cycle of a frame is reached, moves to IDLE. If `en_i` falls mid-frame, moves to STOP.
  - STOP: finishes the current frame, then moves to IDLE. `en_i` re-asserting during STOP returns the block to RUN without a gap.
- **Blanking.** `pixel_o` is forced to 0 whenever `de_o` = 0.

## Timing

- **Pipeline.** Counter state (h,v) in cycle N produces `addr_rd_o` in cycle N+1. `data_i` is valid in cycle N+2. `pixel_o`, `de_o`, `hsync_o` and `vsync_o` for (h,v) are valid in cycle N+3.
- **Alignment.** The sync and de signals pass through matching delay registers, so all outputs are mutually aligned. Latency from address to pixel is exactly 2 cycles.
- **Registered outputs.** All outputs are registered.
- **Reset values.**
  - `addr_rd_o` = 0
  - `pixel_o` = 0
  - `de_o` = 0
  - `frame_start_o` = 0
  - `busy_o` = 0
  - `hsync_o` = `vsync_o` = ~SYNC_ACTIVE
- **Reset mid-frame.** Asserting reset mid-frame forces the reset values immediately and asynchronously. After release, the block is in IDLE and the next enabled frame starts at (0,0).
- **Start-up.** When `en_i` rises in IDLE, (0,0) is processed in the next cycle, so `addr_rd_o` = 0 two cycles after `en_i` rises.
- **Stopping.** When the block stops, the pipeline drains for 3 cycles with valid outputs before the idle values appear.
- **Frame wrap.** The frame wraps with no idle cycle. The next frame's first address is 0.

## Test plan

- **Basic scan.** Preload `frame_buffer` addr 0 = AAAA and addr 10239 = FFFF. Release reset, then set `en_i` = 1. Required: `frame_start_o` pulses with `de_o` rising and `pixel_o` = AAAA, exactly 2 cycles after `addr_rd_o` = 0. The last active pixel of the frame = FFFF.
- **Address sequence.** Required: line 0 addresses are 0..127, line 1 starts at 128, and line 79 ends at 10239. `addr_rd_o` holds 10239 through blanking, then reads 0 at the next frame start. There are exactly 14080 cycles between `frame_start_o` pulses.
- **Sync timing.** Required: `hsync_o` is low for 16 cycles, beginning 136 cycles after each line's first `de_o` rise, with a period of 160. `vsync_o` is low for 320 consecutive cycles per frame, beginning 82×160 cycles after `frame_start_o`.
- **Blanking.** Preload all locations with 1234. Required: 10240 cycles with `de_o` high per frame, and `pixel_o` = 0 in every cycle where `de_o` = 0.
- **Stop and restart.** Drop `en_i` at line 40. Required: the frame completes, then `busy_o` = 0 and idle outputs appear. Re-raise `en_i` during STOP: required no gap between frames. Re-raise `en_i` from IDLE: required `addr_rd_o` = 0 two cycles later.
- **Reset mid-line.** Pulse `resetn_i` low at h=50, v=10. Required: outputs go to reset values before the next clock edge, and after release the restart begins at address 0.

Source files
------------

// File: rtl/fb_scanout_if.sv
// Scan-out bus: frame-buffer read port plus the aligned video outputs.
// The master side is the scan-out engine; the slave side is the frame buffer and display sink.
interface fb_scanout_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] addr_rd_o;
    logic [DATA_WIDTH-1:0] data_i;
    logic [DATA_WIDTH-1:0] pixel_o;
    logic                  de_o;
    logic                  hsync_o;
    logic                  vsync_o;
    logic                  frame_start_o;
    logic                  busy_o;

    modport master (
        output addr_rd_o, pixel_o, de_o, hsync_o, vsync_o, frame_start_o, busy_o,
        input  data_i
    );

    modport slave (
        input  addr_rd_o, pixel_o, de_o, hsync_o, vsync_o, frame_start_o, busy_o,
        output data_i
    );
endinterface

// File: rtl/fb_scanout.sv
// Raster scan-out engine: generates sync/de timing, reads the frame buffer in raster
// order and realigns the one-cycle-latency read data with the delayed timing signals.
module fb_scanout #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned H_ACTIVE    = 128,
    parameter int unsigned H_FP        = 8,
    parameter int unsigned H_SYNC      = 16,
    parameter int unsigned H_BP        = 8,
    parameter int unsigned V_ACTIVE    = 80,
    parameter int unsigned V_FP        = 2,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 4,
    parameter bit          SYNC_ACTIVE = 1'b0
) (
    input  logic          clk_i,
    input  logic          resetn_i,
    input  logic          en_i,
    fb_scanout_if.master  bus
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [HW-1:0]   h_q, h_d;
    logic [VW-1:0]   v_q, v_d;
    logic            scan_c, frame_last_c, active_c, hs_win_c, vs_win_c, first_c;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  vld_s1, de_s1, hs_s1, vs_s1, fs_s1;
    logic                  vld_s2, de_s2, hs_s2, vs_s2, fs_s2;
    logic [DATA_WIDTH-1:0] pixel_q;
    logic                  de_q, hsync_q, vsync_q, fs_q, busy_q;

    // State and raster counters
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= ST_IDLE;
            h_q     <= '0;
            v_q     <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
        end
    end

    // Next state, counter advance and raster decode of the current position
    always_comb begin
        state_d      = state_q;
        h_d          = h_q;
        v_d          = v_q;
        scan_c       = (state_q != ST_IDLE);
        frame_last_c = (h_q == HW'(H_TOTAL - 1)) && (v_q == VW'(V_TOTAL - 1));
        first_c      = scan_c && (h_q == '0) && (v_q == '0);
        active_c     = scan_c && (h_q < HW'(H_ACTIVE)) && (v_q < VW'(V_ACTIVE));
        hs_win_c     = scan_c && (h_q >= HW'(H_ACTIVE + H_FP))
                                && (h_q <  HW'(H_ACTIVE + H_FP + H_SYNC));
        vs_win_c     = scan_c && (v_q >= VW'(V_ACTIVE + V_FP))
                                && (v_q <  VW'(V_ACTIVE + V_FP + V_SYNC));

        if (scan_c) begin
            if (h_q == HW'(H_TOTAL - 1)) begin
                h_d = '0;
                v_d = (v_q == VW'(V_TOTAL - 1)) ? '0 : v_q + VW'(1);
            end else begin
                h_d = h_q + HW'(1);
            end
        end

        case (state_q)
            ST_IDLE: if (en_i) state_d = ST_RUN;
            ST_RUN:  if (!en_i) state_d = frame_last_c ? ST_IDLE : ST_STOP;
            ST_STOP: begin
                if (en_i)              state_d = ST_RUN;
                else if (frame_last_c) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Address stage, two-stage timing delay, and aligned output registers
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            addr_q  <= '0;
            vld_s1  <= 1'b0; de_s1 <= 1'b0; hs_s1 <= 1'b0; vs_s1 <= 1'b0; fs_s1 <= 1'b0;
            vld_s2  <= 1'b0; de_s2 <= 1'b0; hs_s2 <= 1'b0; vs_s2 <= 1'b0; fs_s2 <= 1'b0;
            pixel_q <= '0;
            de_q    <= 1'b0;
            hsync_q <= ~SYNC_ACTIVE;
            vsync_q <= ~SYNC_ACTIVE;
            fs_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            if (!scan_c || first_c) addr_q <= '0;
            else if (active_c)      addr_q <= addr_q + ADDR_WIDTH'(1);

            vld_s1 <= scan_c;   de_s1 <= active_c; hs_s1 <= hs_win_c;
            vs_s1  <= vs_win_c; fs_s1 <= first_c;
            vld_s2 <= vld_s1;   de_s2 <= de_s1;    hs_s2 <= hs_s1;
            vs_s2  <= vs_s1;    fs_s2 <= fs_s1;

            pixel_q <= de_s2 ? bus.data_i : '0;
            de_q    <= de_s2;
            hsync_q <= hs_s2 ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vsync_q <= vs_s2 ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            fs_q    <= fs_s2;
            busy_q  <= vld_s2;
        end
    end

    assign bus.addr_rd_o     = addr_q;
    assign bus.pixel_o       = pixel_q;
    assign bus.de_o          = de_q;
    assign bus.hsync_o       = hsync_q;
    assign bus.vsync_o       = vsync_q;
    assign bus.frame_start_o = fs_q;
    assign bus.busy_o        = busy_q;
endmodule

// File: tb/tb_fb_scanout.sv
// Scoreboard bench for fb_scanout: a frame-position reference model predicts every output
// cycle from raster arithmetic over a frame-buffer image; a monitor compares each cycle.
module tb_fb_scanout;
    localparam int unsigned AW     = 32;
    localparam int unsigned DW     = 16;
    localparam int          H_ACT  = 128;
    localparam int          H_TOT  = 160;
    localparam int          V_ACT  = 80;
    localparam int          NPIX   = H_ACT * V_ACT;
    localparam int          FRAME  = H_TOT * 88;
    localparam int          HS_BEG = 136;
    localparam int          HS_END = 152;
    localparam int          VS_BEG = 82;
    localparam int          VS_END = 84;

    typedef struct packed {
        logic [DW-1:0] pix;
        logic          de;
        logic          hs;
        logic          vs;
        logic          fs;
        logic          busy;
    } out_t;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    logic en     = 1'b0;

    fb_scanout_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    fb_scanout #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .H_ACTIVE(128), .H_FP(8), .H_SYNC(16), .H_BP(8),
        .V_ACTIVE(80), .V_FP(2), .V_SYNC(2), .V_BP(4),
        .SYNC_ACTIVE(1'b0)
    ) dut (
        .clk_i    (clk),
        .resetn_i (resetn),
        .en_i     (en),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Frame buffer model: data valid one cycle after the address
    logic [DW-1:0] mem [NPIX];
    always @(posedge clk)
        bus.data_i <= (bus.addr_rd_o < AW'(NPIX)) ? mem[bus.addr_rd_o[13:0]] : 16'hDEAD;

    int   errors = 0;
    int   checks = 0;
    bit   chk_en = 1'b0;
    bit   m_run  = 1'b0;
    int   m_p    = 0;
    out_t          exp_q [$];
    logic [AW-1:0] addr_q [$];
    out_t          mon_got, mon_exp;
    logic [AW-1:0] mon_addr;

    function automatic out_t idle_out();
        out_t o;
        o.pix = '0; o.de = 1'b0; o.hs = 1'b1; o.vs = 1'b1; o.fs = 1'b0; o.busy = 1'b0;
        return o;
    endfunction

    function automatic out_t exp_out(input bit proc, input int p);
        out_t o;
        int h, v;
        o = idle_out();
        if (proc) begin
            h      = p % H_TOT;
            v      = p / H_TOT;
            o.busy = 1'b1;
            o.de   = (h < H_ACT) && (v < V_ACT);
            if (o.de) o.pix = mem[v * H_ACT + h];
            o.hs   = !((h >= HS_BEG) && (h < HS_END));
            o.vs   = !((v >= VS_BEG) && (v < VS_END));
            o.fs   = (p == 0);
        end
        return o;
    endfunction

    // Address presented for a position: its linear index, or the last one read while blanking
    function automatic logic [AW-1:0] exp_addr(input bit proc, input int p);
        int h, v;
        if (!proc) return '0;
        h = p % H_TOT;
        v = p / H_TOT;
        if (v >= V_ACT) return AW'(NPIX - 1);
        if (h >= H_ACT) return AW'(v * H_ACT + H_ACT - 1);
        return AW'(v * H_ACT + h);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        check({tag, " addr"},  bus.addr_rd_o, 32'h0);
        check({tag, " pixel"}, 32'(bus.pixel_o), 32'h0);
        check({tag, " de"},    32'(bus.de_o), 32'h0);
        check({tag, " fs"},    32'(bus.frame_start_o), 32'h0);
        check({tag, " busy"},  32'(bus.busy_o), 32'h0);
        check({tag, " hsync"}, 32'(bus.hsync_o), 32'h1);
        check({tag, " vsync"}, 32'(bus.vsync_o), 32'h1);
    endtask

    // Called just after a negedge; the outputs already show three cycles of pipeline
    task automatic start_sb();
        exp_q.delete();
        addr_q.delete();
        exp_q.push_back(idle_out());
        exp_q.push_back(idle_out());
        m_run  = 1'b0;
        m_p    = 0;
        chk_en = 1'b1;
    endtask

    // Reference model: frame position processed this cycle; frames continue iff en at the last cycle
    always @(posedge clk) begin
        if (chk_en) begin
            exp_q.push_back(exp_out(m_run, m_p));
            addr_q.push_back(exp_addr(m_run, m_p));
            if (!m_run) begin
                if (en) begin m_run = 1'b1; m_p = 0; end
            end else if (m_p == FRAME - 1) begin
                m_p   = 0;
                m_run = en;
            end else begin
                m_p++;
            end
        end
    end

    // Monitor
    always @(negedge clk) begin
        if (chk_en) begin
            mon_got = {bus.pixel_o, bus.de_o, bus.hsync_o, bus.vsync_o, bus.frame_start_o, bus.busy_o};
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL out_tuple @%0t: no expected entry", $time);
            end else begin
                mon_exp = exp_q.pop_front();
                checks++;
                if (mon_got !== mon_exp) begin
                    errors++;
                    $display("FAIL out_tuple @%0t: got pix=%h de=%b hs=%b vs=%b fs=%b busy=%b expected pix=%h de=%b hs=%b vs=%b fs=%b busy=%b",
                             $time, mon_got.pix, mon_got.de, mon_got.hs, mon_got.vs, mon_got.fs, mon_got.busy,
                             mon_exp.pix, mon_exp.de, mon_exp.hs, mon_exp.vs, mon_exp.fs, mon_exp.busy);
                end
            end
            if (addr_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL addr_rd @%0t: no expected entry", $time);
            end else begin
                mon_addr = addr_q.pop_front();
                check("addr_rd", bus.addr_rd_o, mon_addr);
            end
        end
    end

    task automatic wait_pos(input int pos, input string name);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!(m_run && m_p == pos) && n < 2 * FRAME);
        if (!(m_run && m_p == pos)) begin
            checks++; errors++;
            $display("FAIL %s: position %0d not reached, model at %0d run=%0b", name, pos, m_p, m_run);
        end
    endtask

    initial begin
        for (int i = 0; i < NPIX; i++) mem[i] = DW'($urandom);
        mem[0]        = 16'hAAAA;
        mem[NPIX - 1] = 16'hFFFF;

        repeat (3) @(posedge clk);
        #1 chk_idle("reset");
        @(negedge clk);
        resetn = 1'b1;
        #1 start_sb();

        // First frame after enable: frame_start, de and pixel 4 cycles after en is sampled
        repeat ($urandom_range(3, 9)) @(negedge clk);
        en = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("fs early", 32'(bus.frame_start_o), 32'h0);
        @(posedge clk);
        #1 check("fs first", 32'(bus.frame_start_o), 32'h1);
        check("de first",    32'(bus.de_o), 32'h1);
        check("pixel first", 32'(bus.pixel_o), 32'h0000AAAA);

        // Frame 2: drop en at line 40, re-raise during STOP at line 60
        wait_pos(FRAME - 1, "frame1 end");
        wait_pos(40 * H_TOT, "frame2 line40");
        @(negedge clk); en = 1'b0;
        wait_pos(60 * H_TOT + 17, "frame2 line60");
        @(negedge clk); en = 1'b1;

        // Frame 3: drop en at line 40 and let it stop
        wait_pos(FRAME - 1, "frame2 end");
        wait_pos(40 * H_TOT, "frame3 line40");
        @(negedge clk); en = 1'b0;
        begin
            int n;
            n = 0;
            do begin @(negedge clk); n++; end while (m_run && n < 2 * FRAME);
            repeat (3) @(negedge clk);
            #1 check("busy after stop", 32'(bus.busy_o), 32'h0);
            chk_idle("stopped");
        end

        // Restart from IDLE: addr 0 two cycles later, then 1
        repeat ($urandom_range(3, 30)) @(negedge clk);
        en = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("restart addr0", bus.addr_rd_o, 32'h0);
        @(posedge clk);
        #1 check("restart addr1", bus.addr_rd_o, 32'h1);

        // Asynchronous reset mid-line at h=50, v=10
        wait_pos(10 * H_TOT + 50, "reset point");
        @(negedge clk);
        #1 chk_en = 1'b0;
        resetn = 1'b0;
        #1 chk_idle("async reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        #1 start_sb();

        // Randomized enable toggling
        for (int i = 0; i < 15000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 999) == 0) en = ~en;
        end

        // Drain
        en = 1'b0;
        begin
            int n;
            n = 0;
            do begin @(negedge clk); n++; end while (m_run && n < 2 * FRAME);
            if (m_run) begin
                checks++; errors++;
                $display("FAIL drain: model still running");
            end
        end
        repeat (5) @(negedge clk);
        #1 chk_en = 1'b0;
        chk_idle("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
